// File: rtl/fft_tone_tracker.sv
// Tracks a narrowband tone across FFT frames: per-frame in-band peak search plus a hit/miss tracker FSM.
// Optional build macro FFT_TONE_SNR_CHECK_EN adds an in-band peak-to-mean test to the hit decision.
//
// state     | meaning
// ABSENT    | no tone tracked, waiting for a first hit
// CANDIDATE | consecutive stable hits being counted toward onset
// PRESENT   | tone tracked, anchor follows the peak
// RELEASING | tone still reported, consecutive misses being counted toward offset
module fft_tone_tracker #(
    parameter int NSamples       = 256,
    parameter int W              = 33,
    parameter int K_MIN          = 20,
    parameter int K_MAX          = 100,
    parameter int PEAK_MIN       = 1000,
    parameter int CONFIRM_FRAMES = 3,
    parameter int RELEASE_FRAMES = 2,
    parameter int BIN_TOL        = 1,
    parameter int SNR_SHIFT      = 3,
    localparam int IW            = $clog2(NSamples)
) (
    input  logic          fft_clk,
    input  logic          reset,
    input  logic [W-1:0]  mag,
    input  logic          mag_valid,
    output logic          frame_valid,
    output logic [IW-1:0] tone_bin,
    output logic [W-1:0]  tone_mag,
    output logic          tone_present,
    output logic          tone_onset,
    output logic          tone_offset
);
    localparam logic [1:0] ABSENT    = 2'd0;
    localparam logic [1:0] CANDIDATE = 2'd1;
    localparam logic [1:0] PRESENT   = 2'd2;
    localparam logic [1:0] RELEASING = 2'd3;

    localparam int DW = IW + 1;
    localparam int CW = $clog2(CONFIRM_FRAMES + 1);
    localparam int RW = $clog2(RELEASE_FRAMES + 1);
    localparam logic [IW-1:0] KMIN_I = IW'(K_MIN);
    localparam logic [IW-1:0] KMAX_I = IW'(K_MAX);
    localparam logic [W-1:0]  PEAK_W = W'(PEAK_MIN);
    localparam logic [DW-1:0] TOL_D  = DW'(BIN_TOL);
    localparam logic [CW-1:0] CONF_C = CW'(CONFIRM_FRAMES);
    localparam logic [RW-1:0] REL_C  = RW'(RELEASE_FRAMES);

    logic [IW-1:0] bin_cnt, peak_idx, peak_idx_nxt, anchor;
    logic [W-1:0]  peak_mag, peak_mag_nxt;
    logic          first_bin, last_bin, in_band;
    logic [1:0]    state;
    logic [CW-1:0] conf_cnt, conf_inc;
    logic [RW-1:0] miss_cnt, miss_inc;
    logic [DW-1:0] bin_diff;
    logic          snr_ok, hit, stable;

    assign first_bin = (bin_cnt == '0);
    assign last_bin  = &bin_cnt;
    assign in_band   = (bin_cnt >= KMIN_I) && (bin_cnt <= KMAX_I);

    // Bin 0 starts a fresh search; strict compare keeps the lowest bin on ties.
    always_comb begin
        peak_mag_nxt = first_bin ? '0 : peak_mag;
        peak_idx_nxt = first_bin ? '0 : peak_idx;
        if (in_band && (mag > peak_mag_nxt)) begin
            peak_mag_nxt = mag;
            peak_idx_nxt = bin_cnt;
        end
    end

    always_ff @(posedge fft_clk or posedge reset) begin
        if (reset) begin
            bin_cnt     <= '0;
            peak_mag    <= '0;
            peak_idx    <= '0;
            frame_valid <= 1'b0;
            tone_bin    <= '0;
            tone_mag    <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (mag_valid) begin
                bin_cnt  <= bin_cnt + 1'b1;
                peak_mag <= peak_mag_nxt;
                peak_idx <= peak_idx_nxt;
                if (last_bin) begin
                    frame_valid <= 1'b1;
                    tone_bin    <= peak_idx_nxt;
                    tone_mag    <= peak_mag_nxt;
                end
            end
        end
    end

`ifdef FFT_TONE_SNR_CHECK_EN
    localparam int SW = W + IW;
    localparam int PW = W + IW + SNR_SHIFT + 1;
    localparam int NB = K_MAX - K_MIN + 1;

    logic [SW-1:0] acc, acc_nxt, frame_sum;

    always_comb begin
        acc_nxt = first_bin ? '0 : acc;
        if (in_band)
            acc_nxt = acc_nxt + SW'(mag);
    end

    always_ff @(posedge fft_clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if (mag_valid) begin
            acc <= acc_nxt;
            if (last_bin)
                frame_sum <= acc_nxt;
        end
    end

    // peak * band_width >= sum << shift  is  peak >= 2^shift * mean, without a divider
    assign snr_ok = (PW'(tone_mag) * PW'(NB)) >= (PW'(frame_sum) << SNR_SHIFT);
`else
    assign snr_ok = 1'b1;
`endif

    assign hit      = (tone_mag >= PEAK_W) && snr_ok;
    assign bin_diff = (tone_bin >= anchor) ? ({1'b0, tone_bin} - {1'b0, anchor})
                                           : ({1'b0, anchor} - {1'b0, tone_bin});
    assign stable   = hit && (bin_diff <= TOL_D);
    assign conf_inc = (&conf_cnt) ? conf_cnt : conf_cnt + 1'b1;
    assign miss_inc = (&miss_cnt) ? miss_cnt : miss_cnt + 1'b1;

    assign tone_present = (state == PRESENT) || (state == RELEASING);

    always_ff @(posedge fft_clk or posedge reset) begin
        if (reset) begin
            state       <= ABSENT;
            conf_cnt    <= '0;
            miss_cnt    <= '0;
            anchor      <= '0;
            tone_onset  <= 1'b0;
            tone_offset <= 1'b0;
        end else begin
            tone_onset  <= 1'b0;
            tone_offset <= 1'b0;
            if (frame_valid) begin
                case (state)
                    ABSENT: if (hit) begin
                        anchor   <= tone_bin;
                        conf_cnt <= CW'(1);
                        if (CONFIRM_FRAMES == 1) begin
                            state      <= PRESENT;
                            tone_onset <= 1'b1;
                        end else begin
                            state <= CANDIDATE;
                        end
                    end
                    CANDIDATE: if (stable) begin
                        anchor   <= tone_bin;
                        conf_cnt <= conf_inc;
                        if (conf_inc >= CONF_C) begin
                            state      <= PRESENT;
                            tone_onset <= 1'b1;
                        end
                    end else if (hit) begin
                        anchor   <= tone_bin;
                        conf_cnt <= CW'(1);
                    end else begin
                        state    <= ABSENT;
                        conf_cnt <= '0;
                    end
                    PRESENT: if (stable) begin
                        anchor <= tone_bin;
                    end else begin
                        miss_cnt <= RW'(1);
                        if (RELEASE_FRAMES == 1) begin
                            state       <= ABSENT;
                            tone_offset <= 1'b1;
                            miss_cnt    <= '0;
                            conf_cnt    <= '0;
                        end else begin
                            state <= RELEASING;
                        end
                    end
                    default: if (stable) begin
                        state    <= PRESENT;
                        anchor   <= tone_bin;
                        miss_cnt <= '0;
                    end else begin
                        miss_cnt <= miss_inc;
                        if (miss_inc >= REL_C) begin
                            state       <= ABSENT;
                            tone_offset <= 1'b1;
                            miss_cnt    <= '0;
                            conf_cnt    <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fft_tone_tracker.sv
// Scoreboard bench for fft_tone_tracker: driver pushes per-frame expectations from a reference model,
// a negedge monitor pops them when frame_valid appears and checks the tracker pulses a cycle later.
module tb_fft_tone_tracker;
    localparam int NS = 256;
    localparam int W = 33;
    localparam int K_MIN = 20;
    localparam int K_MAX = 100;
    localparam longint PEAK_MIN = 1000;
    localparam int CONFIRM = 3;
    localparam int RELEASE = 2;
    localparam int TOL = 1;
    localparam int SNR_SHIFT = 3;

    logic         fft_clk = 1'b0;
    logic         reset;
    logic [W-1:0] mag;
    logic         mag_valid;
    logic         frame_valid;
    logic [7:0]   tone_bin;
    logic [W-1:0] tone_mag;
    logic         tone_present, tone_onset, tone_offset;

    fft_tone_tracker dut (
        .fft_clk(fft_clk), .reset(reset), .mag(mag), .mag_valid(mag_valid),
        .frame_valid(frame_valid), .tone_bin(tone_bin), .tone_mag(tone_mag),
        .tone_present(tone_present), .tone_onset(tone_onset), .tone_offset(tone_offset)
    );

    always #5 fft_clk = ~fft_clk;

    typedef struct {
        int     bin;
        longint mag;
        bit     onset;
        bit     offset;
        bit     present;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    bit     pend = 0;
    bit     last_present = 0;
    logic [W-1:0] fr [NS];

    // tracker reference: trk 0=idle, 1=confirming, 2=tracked, 3=tracked but missing
    int m_trk, m_conf, m_miss, m_anchor;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_trk = 0; m_conf = 0; m_miss = 0; m_anchor = 0;
    endtask

    task automatic model_frame(output exp_t e);
        longint pk = 0, sum = 0;
        int idx = 0, d;
        bit hit, stable, was;
        for (int b = K_MIN; b <= K_MAX; b++) begin
            sum += longint'(fr[b]);
            if (longint'(fr[b]) > pk) begin pk = longint'(fr[b]); idx = b; end
        end
        hit = (pk >= PEAK_MIN);
`ifdef FFT_TONE_SNR_CHECK_EN
        hit = hit && (pk * (K_MAX - K_MIN + 1) >= (sum << SNR_SHIFT));
`endif
        d = idx - m_anchor;
        if (d < 0) d = -d;
        stable = hit && (d <= TOL);
        was = (m_trk >= 2);
        if (m_trk == 0) begin
            if (hit) begin m_anchor = idx; m_conf = 1; m_trk = (CONFIRM == 1) ? 2 : 1; end
        end else if (m_trk == 1) begin
            if (stable) begin
                m_anchor = idx; m_conf++;
                if (m_conf >= CONFIRM) m_trk = 2;
            end else if (hit) begin m_anchor = idx; m_conf = 1; end
            else begin m_trk = 0; m_conf = 0; end
        end else if (m_trk == 2) begin
            if (stable) m_anchor = idx;
            else begin m_miss = 1; m_trk = (RELEASE == 1) ? 0 : 3; end
        end else begin
            if (stable) begin m_trk = 2; m_miss = 0; m_anchor = idx; end
            else begin
                m_miss++;
                if (m_miss >= RELEASE) begin m_trk = 0; m_miss = 0; m_conf = 0; end
            end
        end
        e.bin = idx; e.mag = pk;
        e.present = (m_trk >= 2);
        e.onset = !was && e.present;
        e.offset = was && !e.present;
    endtask

    task automatic drive_bins(input int n);
        for (int b = 0; b < n; b++) begin
            while ($urandom_range(0, 4) == 0) begin
                @(negedge fft_clk);
                mag_valid = 1'b0;
                mag = W'($urandom);
            end
            @(negedge fft_clk);
            mag_valid = 1'b1;
            mag = fr[b];
        end
        @(negedge fft_clk);
        mag_valid = 1'b0;
    endtask

    task automatic send_frame();
        exp_t e;
        model_frame(e);
        sb.push_back(e);
        drive_bins(NS);
    endtask

    task automatic clear_fr();
        for (int b = 0; b < NS; b++) fr[b] = '0;
    endtask

    task automatic tone_frame(input int bin, input longint m);
        clear_fr();
        fr[bin] = W'(m);
        send_frame();
    endtask

    // monitor
    exp_t pe;
    initial begin
        forever begin
            @(negedge fft_clk);
            if (reset) begin
                pend = 0;
                last_present = 0;
            end else begin
                if (pend) begin
                    check("onset", tone_onset, pe.onset);
                    check("offset", tone_offset, pe.offset);
                    check("present", tone_present, pe.present);
                    last_present = pe.present;
                    pend = 0;
                end else begin
                    check("idle_onset", tone_onset, 0);
                    check("idle_offset", tone_offset, 0);
                    check("present_hold", tone_present, last_present);
                end
                if (frame_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame_valid", 1, 0);
                    end else begin
                        pe = sb.pop_front();
                        check("tone_bin", tone_bin, pe.bin);
                        check("tone_mag", longint'(tone_mag), pe.mag);
                        pend = 1;
                    end
                end
            end
        end
    end

    initial begin
        int a, tb_bin, j;
        reset = 1'b1; mag_valid = 1'b0; mag = '0;
        model_reset();
        repeat (3) @(negedge fft_clk);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_tone_bin", tone_bin, 0);
        check("rst_tone_mag", longint'(tone_mag), 0);
        check("rst_present", tone_present, 0);
        check("rst_onset", tone_onset, 0);
        check("rst_offset", tone_offset, 0);
        reset = 1'b0;

        // steady tone -> onset on the third frame
        repeat (3) tone_frame(50, 5000);
        repeat (2) tone_frame(50, 0);
        // drift beyond tolerance restarts confirmation
        tone_frame(50, 5000); tone_frame(52, 5000); tone_frame(53, 5000); tone_frame(54, 5000);
        // miss, hit, miss, miss
        tone_frame(54, 0); tone_frame(54, 5000); tone_frame(54, 0); tone_frame(54, 0);
        // out-of-band peak ignored, tie picks lowest bin
        clear_fr(); fr[10] = 9000; fr[60] = 2000; send_frame();
        clear_fr(); fr[30] = 2000; fr[40] = 2000; send_frame();
        // PEAK_MIN boundary
        tone_frame(70, 999); tone_frame(70, 1000);
        // flat spectrum
        for (int b = 0; b < NS; b++) fr[b] = 1200;
        send_frame();
        repeat (2) tone_frame(70, 0);

        // mid-frame reset while tracking
        repeat (3) tone_frame(70, 5000);
        clear_fr(); fr[70] = 5000;
        drive_bins(128);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge fft_clk);
        check("midrst_present", tone_present, 0);
        check("midrst_frame_valid", frame_valid, 0);
        reset = 1'b0;
        tone_frame(80, 3000);

        // randomized frames around a wandering anchor
        a = $urandom_range(K_MIN + 3, K_MAX - 3);
        for (int f = 0; f < 40; f++) begin
            for (int b = 0; b < NS; b++) fr[b] = W'($urandom_range(0, 900));
            if ($urandom_range(0, 5) == 0) fr[$urandom_range(0, K_MIN - 1)] = W'($urandom_range(0, 200000));
            if ($urandom_range(0, 3) != 0) begin
                j = $urandom_range(0, 4);
                tb_bin = a + j - 2;
                case ($urandom_range(0, 5))
                    0: fr[tb_bin] = W'(PEAK_MIN - 1);
                    1: fr[tb_bin] = {1'b1, 32'($urandom)};
                    default: fr[tb_bin] = W'($urandom_range(1000, 100000));
                endcase
                if ($urandom_range(0, 7) == 0) fr[tb_bin + 1] = fr[tb_bin];
                if (j != 2 && $urandom_range(0, 1) == 0) a = tb_bin;
            end
            send_frame();
        end

        for (int i = 0; i < 3000 && (sb.size() != 0 || pend); i++) @(negedge fft_clk);
        check("scoreboard_drained", sb.size() + int'(pend), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_tone_tracker.md
FFT_TONE_TRACKER -- requirements
Module: fft_tone_tracker

Interface
REQ-001: Parameter NSamples, default 256, bins per FFT frame; power of two, at least 8.
REQ-002: Parameter W, default 33, magnitude-squared width.
REQ-003: Parameter K_MIN, default 20, lowest bin in the search band (inclusive).
REQ-004: Parameter K_MAX, default 100, highest bin in the search band (inclusive); K_MIN <= K_MAX < NSamples.
REQ-005: Parameter PEAK_MIN, default 1000, minimum in-band peak magnitude for a frame hit.
REQ-006: Parameter CONFIRM_FRAMES, default 3, consecutive stable hits required for onset; at least 1.
REQ-007: Parameter RELEASE_FRAMES, default 2, consecutive misses required for offset; at least 1.
REQ-008: Parameter BIN_TOL, default 1, maximum bin drift between consecutive hits that still counts as stable.
REQ-009: Parameter SNR_SHIFT, default 3, in-band peak-to-mean ratio of 2^SNR_SHIFT.
REQ-010: fft_clk  input  1  clock; all logic is in this domain.
REQ-011: reset  input  1  reset, asynchronous, active-high.
REQ-012: mag  input  W  magnitude-squared bin value.
REQ-013: mag_valid  input  1  mag qualifier; bins arrive in order 0..NSamples-1 and may have gaps.
REQ-014: frame_valid  output  1  one-cycle pulse when a frame's result is ready.
REQ-015: tone_bin  output  $clog2(NSamples)  in-band peak bin of the last frame.
REQ-016: tone_mag  output  W  in-band peak magnitude of the last frame.
REQ-017: tone_present  output  1  level output, high while a tone is tracked.
REQ-018: tone_onset  output  1  one-cycle pulse on the transition to tracked.
REQ-019: tone_offset  output  1  one-cycle pulse on the transition to not tracked.

Function
REQ-020: An internal bin counter shall advance on each mag_valid and wrap from NSamples-1 to 0; a gap in mag_valid shall not advance it.
REQ-021: The in-band peak shall be updated only for bins K_MIN..K_MAX, using strict greater-than so the lowest bin wins a tie; peak and index shall clear at bin 0.
REQ-022: frame_valid, tone_bin and tone_mag shall update exactly 1 cycle after the mag_valid carrying bin NSamples-1.
REQ-023: A frame is a hit when tone_mag >= PEAK_MIN and the SNR test passes (REQ-033); otherwise it is a miss.
REQ-024: The FSM states shall be ABSENT, CANDIDATE, PRESENT and RELEASING; it shall evaluate only on frame_valid.
REQ-025: ABSENT: a hit sets the anchor to tone_bin and confirm count to 1, then moves to CANDIDATE; if CONFIRM_FRAMES=1, it moves directly to PRESENT with onset.
REQ-026: CANDIDATE: a hit with |tone_bin-anchor| <= BIN_TOL increments the count and updates the anchor; when the count reaches CONFIRM_FRAMES, it moves to PRESENT.
REQ-027: CANDIDATE: a hit outside tolerance restarts with count 1 at the new anchor; a miss returns to ABSENT.
REQ-028: PRESENT: a stable hit updates the anchor; a miss or unstable hit sets the miss count to 1 and moves to RELEASING, or to ABSENT if RELEASE_FRAMES=1.
REQ-029: RELEASING: a stable hit returns to PRESENT with the miss count cleared; otherwise the miss count increments, and on reaching RELEASE_FRAMES the FSM moves to ABSENT.
REQ-030: tone_present shall be high in PRESENT and RELEASING; tone_onset and tone_offset shall pulse in the same cycle as the state register change, 1 cycle after frame_valid.
REQ-031: Counters shall saturate and never wrap; the anchor difference shall be computed unsigned-safe, with an absolute value one bit wider than the index.

Reset
REQ-032: Reset shall clear the state to ABSENT and zero the bin counter, peak, accumulator, counters, anchor and all outputs; reset mid-frame shall discard the partial frame, with the next mag_valid treated as bin 0.

Configuration
REQ-033: Macro FFT_TONE_SNR_CHECK_EN: when defined, the block sums in-band mags (width W+$clog2(NSamples)), and a hit also requires tone_mag*(K_MAX-K_MIN+1) >= sum<<SNR_SHIFT; when undefined, there is no accumulator and only PEAK_MIN applies.

Verification (NSamples=256, K_MIN=20, K_MAX=100, PEAK_MIN=1000, CONFIRM=3, RELEASE=2, TOL=1, SNR_SHIFT=3)
REQ-034: Three frames with bin 50 at 5000 and all others 0 -> frame_valid after each frame; tone_onset 1 cycle after the 3rd frame_valid; tone_present=1.
REQ-035: Peaks at 50, 52, 53 -> no onset after frame 2 (count restarts); onset after frame 4 at bin 54.
REQ-036: Tracked tone, then miss, hit, miss, miss -> tone_offset only after the 5th frame; tone_present stays high through the single miss.
REQ-037: Bin 10 at 9000 and bin 60 at 2000 -> tone_bin=60, tone_mag=2000; equal 2000 values at bins 30 and 40 -> tone_bin=30.
REQ-038: With SNR enabled, a flat 1200 in every bin -> miss and no onset; reset asserted at bin 128 -> next frame result counts from the new bin 0.
